// File: rtl/alu_seq_unit.sv
// Multi-cycle 12-bit integer execution unit with valid/ready request and response ports.
// Add/sub/compare finish in one calculate cycle; multiply is an iterative shift-add over WIDTH cycles.
module alu_seq_unit #(
   parameter int WIDTH = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_opcode,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_ovf,
   output logic             rsp_err,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [2:0] OP_ADD  = 3'b001;
   localparam logic [2:0] OP_SUB  = 3'b010;
   localparam logic [2:0] OP_UMUL = 3'b011;
   localparam logic [2:0] OP_SMUL = 3'b100;
   localparam logic [2:0] OP_CMP  = 3'b111;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t state, state_next;

   logic [2:0]         op_q;
   logic [WIDTH-1:0]   a_q, b_q;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] acc, mcand, acc_next, prod;
   logic [WIDTH-1:0]   mplier;
   logic               neg;

   logic               accept, req_mul, req_smul, op_mul;
   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     sum, diff;
   logic [WIDTH-1:0]   result_next;
   logic               ovf_next, err_next;

   assign accept    = req_valid && req_ready;
   assign req_mul   = (req_opcode == OP_UMUL) || (req_opcode == OP_SMUL);
   assign req_smul  = (req_opcode == OP_SMUL);
   assign op_mul    = (op_q == OP_UMUL) || (op_q == OP_SMUL);

   // Signed multiply runs on magnitudes; the most negative value maps to its unsigned magnitude.
   assign a_neg = req_smul && req_a[WIDTH-1];
   assign b_neg = req_smul && req_b[WIDTH-1];
   assign mag_a = a_neg ? (~req_a) + WIDTH'(1) : req_a;
   assign mag_b = b_neg ? (~req_b) + WIDTH'(1) : req_b;

   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == DONE);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = CALC;
         CALC:    if (!op_mul || cnt == '0) state_next = DONE;
         DONE:    if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // prod is only meaningful on the final multiply iteration, when it includes the last partial product.
   always_comb begin
      acc_next    = acc + (mplier[0] ? mcand : '0);
      prod        = neg ? (~acc_next) + (2*WIDTH)'(1) : acc_next;
      sum         = {1'b0, a_q} + {1'b0, b_q};
      diff        = {1'b0, a_q} - {1'b0, b_q};
      result_next = '0;
      ovf_next    = 1'b0;
      err_next    = 1'b0;
      case (op_q)
         OP_ADD: begin
            result_next = sum[WIDTH-1:0];
            ovf_next    = sum[WIDTH];
         end
         OP_SUB: begin
            result_next = diff[WIDTH-1:0];
            ovf_next    = diff[WIDTH];
         end
         OP_UMUL: begin
            result_next = prod[WIDTH-1:0];
            ovf_next    = |prod[2*WIDTH-1:WIDTH];
         end
         OP_SMUL: begin
            result_next = prod[WIDTH-1:0];
            ovf_next    = (|prod[2*WIDTH-1:WIDTH-1]) && !(&prod[2*WIDTH-1:WIDTH-1]);
         end
         OP_CMP: begin
            if (a_q == b_q)                        result_next = '0;
            else if ($signed(a_q) > $signed(b_q))  result_next = WIDTH'(1);
            else                                   result_next = '1;
         end
         default: err_next = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         cnt        <= '0;
         acc        <= '0;
         mcand      <= '0;
         mplier     <= '0;
         neg        <= 1'b0;
         rsp_result <= '0;
         rsp_ovf    <= 1'b0;
         rsp_err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op_q   <= req_opcode;
                  a_q    <= req_a;
                  b_q    <= req_b;
                  cnt    <= req_mul ? CW'(WIDTH-1) : '0;
                  acc    <= '0;
                  mcand  <= {{WIDTH{1'b0}}, mag_a};
                  mplier <= mag_b;
                  neg    <= a_neg ^ b_neg;
               end
            end
            CALC: begin
               if (op_mul) begin
                  acc    <= acc_next;
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
                  if (cnt != '0) cnt <= cnt - CW'(1);
               end
               if (state_next == DONE) begin
                  rsp_result <= result_next;
                  rsp_ovf    <= ovf_next;
                  rsp_err    <= err_next;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit: directed cases from the behaviour description,
// backpressure, mid-operation reset and a random back-to-back run against an arithmetic model.
module tb_alu_seq_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_opcode;
   logic [11:0] req_a, req_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [11:0] rsp_result;
   logic        rsp_ovf, rsp_err, busy;

   int nvec = 0;
   int nmis = 0;
   int cycle = 0;

   alu_seq_unit #(.WIDTH(12)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_opcode (req_opcode),
      .req_a      (req_a),
      .req_b      (req_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_ovf    (rsp_ovf),
      .rsp_err    (rsp_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nmis++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operand values.
   function automatic void model(input logic [2:0] op, input logic [11:0] a, input logic [11:0] b,
                                 output logic [11:0] r, output logic o, output logic e, output int lat);
      int ua, ub, sa, sb, p;
      ua = int'(a);
      ub = int'(b);
      sa = a[11] ? ua - 4096 : ua;
      sb = b[11] ? ub - 4096 : ub;
      r = 12'h000; o = 1'b0; e = 1'b0; lat = 1;
      case (op)
         3'b001: begin p = ua + ub; r = p[11:0]; o = (p > 4095); end
         3'b010: begin p = ua - ub; r = p[11:0]; o = (ua < ub); end
         3'b011: begin p = ua * ub; r = p[11:0]; o = (p > 4095); lat = 12; end
         3'b100: begin p = sa * sb; r = p[11:0]; o = (p > 2047) || (p < -2048); lat = 12; end
         3'b111: r = (sa == sb) ? 12'h000 : (sa > sb) ? 12'h001 : 12'hFFF;
         default: e = 1'b1;
      endcase
   endfunction

   task automatic applyStimulus(input logic [2:0] op, input logic [11:0] a, input logic [11:0] b,
                                output int acc_cyc);
      int n = 0;
      req_valid  = 1'b1;
      req_opcode = op;
      req_a      = a;
      req_b      = b;
      while (!req_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      check("accept_wait", 32'(n < 50), 32'd1);
      @(posedge clk); #1;
      acc_cyc    = cycle;
      req_valid  = 1'b0;
      req_opcode = 3'($urandom);
      req_a      = 12'($urandom);
      req_b      = 12'($urandom);
   endtask

   task automatic checkOutput(input string tag, input logic [2:0] op, input logic [11:0] a,
                              input logic [11:0] b);
      logic [11:0] er;
      logic        eo, ee;
      int          lat;
      int          n = 0;
      model(op, a, b, er, eo, ee, lat);
      while (!rsp_valid && n < 40) begin
         @(posedge clk); #1; n++;
      end
      check($sformatf("%s_latency", tag), 32'(n), 32'(lat));
      check($sformatf("%s_result", tag), 32'(rsp_result), 32'(er));
      check($sformatf("%s_ovf", tag), 32'(rsp_ovf), 32'(eo));
      check($sformatf("%s_err", tag), 32'(rsp_err), 32'(ee));
   endtask

   task automatic finishResponse(input logic keep_ready, output int rsp_cyc);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_cyc   = cycle;
      rsp_ready = keep_ready;
      check("post_rsp_req_ready", 32'(req_ready), 32'd1);
      check("post_rsp_rsp_valid", 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      int acc_cyc, rsp_cyc;
      logic seen;
      logic [2:0]  op;
      logic [11:0] a, b;

      rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
      req_opcode = 3'b000; req_a = '0; req_b = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_result", 32'(rsp_result), 32'd0);
      check("rst_ovf_err", 32'({rsp_ovf, rsp_err}), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("idle_req_ready", 32'(req_ready), 32'd1);

      // Directed operations, each fully handshaken before the next.
      applyStimulus(3'b001, 12'h0DF, 12'h0B6, acc_cyc);
      checkOutput("add", 3'b001, 12'h0DF, 12'h0B6);
      check("add_value", 32'(rsp_result), 32'h195);
      finishResponse(1'b0, rsp_cyc);
      applyStimulus(3'b010, 12'h0DF, 12'h0B6, acc_cyc);
      checkOutput("sub", 3'b010, 12'h0DF, 12'h0B6);
      check("sub_value", 32'(rsp_result), 32'h029);
      finishResponse(1'b0, rsp_cyc);
      applyStimulus(3'b011, 12'h007, 12'h005, acc_cyc);
      checkOutput("umul_7x5", 3'b011, 12'h007, 12'h005);
      check("umul_7x5_value", 32'(rsp_result), 32'h023);
      finishResponse(1'b0, rsp_cyc);
      applyStimulus(3'b100, 12'h007, 12'hFFB, acc_cyc);
      checkOutput("smul_7xm5", 3'b100, 12'h007, 12'hFFB);
      check("smul_7xm5_value", 32'({rsp_ovf, rsp_result}), 32'h0FDD);
      finishResponse(1'b0, rsp_cyc);
      applyStimulus(3'b011, 12'h007, 12'hFFB, acc_cyc);
      checkOutput("umul_7xffb", 3'b011, 12'h007, 12'hFFB);
      check("umul_7xffb_value", 32'({rsp_ovf, rsp_result}), 32'h1FDD);
      finishResponse(1'b0, rsp_cyc);
      applyStimulus(3'b111, 12'h160, 12'h160, acc_cyc);
      checkOutput("cmp_eq", 3'b111, 12'h160, 12'h160);
      finishResponse(1'b0, rsp_cyc);
      applyStimulus(3'b111, 12'h001, 12'hFFF, acc_cyc);
      checkOutput("cmp_gt", 3'b111, 12'h001, 12'hFFF);
      check("cmp_gt_value", 32'(rsp_result), 32'h001);
      finishResponse(1'b0, rsp_cyc);
      applyStimulus(3'b111, 12'h800, 12'h7FF, acc_cyc);
      checkOutput("cmp_lt", 3'b111, 12'h800, 12'h7FF);
      check("cmp_lt_value", 32'(rsp_result), 32'hFFF);
      finishResponse(1'b0, rsp_cyc);

      // Unsupported opcode held under backpressure while new requests are offered.
      applyStimulus(3'b101, 12'h3A5, 12'h15C, acc_cyc);
      checkOutput("unsup", 3'b101, 12'h3A5, 12'h15C);
      for (int i = 0; i < 5; i++) begin
         req_valid  = (i % 2 == 0);
         req_opcode = 3'b001;
         @(posedge clk); #1;
         check("bp_result", 32'(rsp_result), 32'h000);
         check("bp_err", 32'(rsp_err), 32'd1);
         check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
         check("bp_req_ready", 32'(req_ready), 32'd0);
      end
      req_valid = 1'b0;
      finishResponse(1'b0, rsp_cyc);
      @(posedge clk); #1;
      check("bp_no_stray_accept", 32'(busy), 32'd0);

      // Reset four cycles into a multiply must abort it silently.
      applyStimulus(3'b011, 12'h007, 12'h005, acc_cyc);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
      check("abort_result", 32'({rsp_ovf, rsp_err, rsp_result}), 32'd0);
      check("abort_req_ready", 32'(req_ready), 32'd1);
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         seen = seen | rsp_valid;
      end
      check("abort_no_response", 32'(seen), 32'd0);
      applyStimulus(3'b001, 12'h001, 12'h001, acc_cyc);
      checkOutput("post_abort_add", 3'b001, 12'h001, 12'h001);
      check("post_abort_value", 32'(rsp_result), 32'h002);
      finishResponse(1'b1, rsp_cyc);

      // Back-to-back random operations with the consumer always ready.
      for (int i = 0; i < 10; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = 12'($urandom);
         b  = 12'($urandom);
         applyStimulus(op, a, b, acc_cyc);
         check("b2b_turnaround", 32'(acc_cyc), 32'(rsp_cyc + 1));
         checkOutput($sformatf("b2b%0d_op%0d", i, op), op, a, b);
         @(posedge clk); #1;
         rsp_cyc = cycle;
         check("b2b_req_ready", 32'(req_ready), 32'd1);
      end

      $display("[TB] == %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule

// File: doc/alu_seq_unit.md
# alu_seq_unit

Handshake-driven, multi-cycle 12-bit integer execution unit that uses the team's 3-bit ALU opcode encoding. It accepts one operation at a time on a valid/ready request port and returns the result on a valid/ready response port. Multiplication is iterative (shift-add), so the unit can sit between an instruction sequencer and the register file without a combinational multiplier. It handles the integer subset of the ALU opcodes. Floating-point opcodes are rejected with an error flag.

## Interface
- `WIDTH`, default 12: operand and result width. Only 12 is verified.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request.
- `req_opcode` in 3: operation select.
- `req_a` in 12: operand A.
- `req_b` in 12: operand B.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_result` out 12: result.
- `rsp_ovf` out 1: overflow, carry or borrow flag.
- `rsp_err` out 1: unsupported opcode.
- `busy` out 1: high whenever state is not IDLE.

## Operation
- Opcode map:
  - 001 add
  - 010 sub (A−B)
  - 011 unsigned multiply
  - 100 signed multiply
  - 111 compare
  - 000, 101 and 110 are unsupported.
- Operands and opcode are captured into internal registers on the accept edge (`req_valid && req_ready`). Later input changes are ignored.
- Add: result is (A+B)[11:0]. ovf is the carry out of bit 11.
- Sub: result is (A−B)[11:0]. ovf is the borrow, i.e. A<B unsigned.
- Multiply uses a 24-bit shift-add accumulator over 12 iterations, one multiplier bit per cycle, LSB first. The result is the low 12 bits of the product; these are identical for the signed and unsigned opcodes.
  - Unsigned (011): ovf = (product[23:12] != 0).
  - Signed (100): operands are multiplied as magnitudes and the 24-bit product is negated if the signs differ. ovf = 1 if product[23:11] is not all zeros and not all ones.
- Compare uses two's-complement signed comparison. Result is 12'h000 if A==B, 12'h001 if A>B, 12'hFFF if A<B. ovf = 0.
- Unsupported opcode: result 12'h000, ovf = 0, err = 1.
- For every supported opcode, err = 0.
- State machine:
  - IDLE → CALC on accept. The iteration counter is loaded with 11 for multiply and 0 otherwise.
  - CALC: add, sub, compare and unsupported opcodes write the result registers and go to DONE on the next edge. Multiply performs one iteration per edge and goes to DONE on the edge where the counter reaches 0; the sign fix-up and ovf computation happen on that same edge.
  - DONE: `rsp_valid` = 1. On an edge with `rsp_ready` = 1 → IDLE. Otherwise stay in DONE with result and flags held stable.
- `req_ready` = (state == IDLE). A request cannot be accepted in the same cycle as a response handshake.

## Timing
- Reset values: state IDLE, `req_ready` = 1, `rsp_valid` = 0, `rsp_result` = 0, `rsp_ovf` = 0, `rsp_err` = 0, `busy` = 0, counter = 0.
- `rst` is sampled at the edge. Asserting it in CALC or DONE aborts the operation with no response. After the reset edge all outputs are at reset values, and `req_ready` = 1 in the first cycle after `rst` deasserts.
- Latency, counted from the accept edge E to the first cycle `rsp_valid` = 1:
  - Add, sub, compare and unsupported: `rsp_valid` is high after edge E+1.
  - Multiply: `rsp_valid` is high after edge E+12.
- Minimum turnaround: response accepted at edge R gives `req_ready` = 1 after R, so the next accept is at R+1 at the earliest.
- The response outputs are registered. `rsp_result`, `rsp_ovf` and `rsp_err` change only on the edge entering DONE or on reset.
- While `rsp_valid` = 0, `rsp_result` holds its last value; consumers must not sample it.
- `req_valid` may drop or change before acceptance without effect. `rsp_ready` is ignored outside DONE.

## Test plan
- Add: opcode 001, A=12'h0DF, B=12'h0B6 → result 12'h195, ovf 0, err 0, `rsp_valid` after edge E+1. Sub, same operands → result 12'h029, ovf 0.
- Multiply:
  - Opcode 011, A=7, B=5 → result 12'h023, ovf 0, `rsp_valid` after edge E+12 and not before.
  - Opcode 100, A=12'h007, B=12'hFFB → result 12'hFDD, ovf 0.
  - Opcode 011 with the same operands → result 12'hFDD, ovf 1.
- Compare, opcode 111:
  - A=B=12'h160 → 12'h000.
  - A=12'h001, B=12'hFFF → 12'h001, because 1 > −1 signed.
  - A=12'h800, B=12'h7FF → 12'hFFF.
- Backpressure and error: opcode 101 with `rsp_ready` held low 5 cycles → result 12'h000 and err 1, stable all 5 cycles; `req_ready` = 0 and a toggling `req_valid` is not accepted; release → IDLE, `req_ready` = 1 the next cycle.
- Reset mid-operation: `rst` asserted 4 cycles into a 7×5 multiply → `rsp_valid` never rises. A following add of 1+1 returns 12'h002 with normal latency.
- Back-to-back: 10 random operations with `rsp_ready` tied high → each accept occurs exactly one cycle after the previous response handshake, and every result matches a reference model.
